// File: rtl/mmcm_ps_pkg.sv
// Shared definitions for the MMCM fine-phase-shift initiator.
package mmcm_ps_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAN  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } ps_state_t;

  // 56 fine steps per VCO period times CLKOUT divide 5
  localparam int unsigned DEF_STEPS_PER_CYCLE = 280;

  // Nominal PSCLK cycles from PSEN to PSDONE on the MMCM primitive
  localparam int unsigned PSDONE_LATENCY = 12;

endpackage

// File: rtl/ps_wrap_dist.sv
// Modular forward distance from from_pos to to_pos on a ring of STEPS_PER_CYCLE
// positions, plus the shortest-path direction (a tie increments).
module ps_wrap_dist
  import mmcm_ps_pkg::*;
#(
  parameter int unsigned POS_W           = 16,
  parameter int unsigned STEPS_PER_CYCLE = DEF_STEPS_PER_CYCLE
) (
  input  logic [POS_W-1:0] from_pos,
  input  logic [POS_W-1:0] to_pos,
  output logic [POS_W-1:0] dist_up,
  output logic             dir_inc
);

  localparam logic [POS_W:0] STEPS_X = (POS_W+1)'(STEPS_PER_CYCLE);
  localparam logic [POS_W:0] HALF_X  = (POS_W+1)'(STEPS_PER_CYCLE / 2);

  logic [POS_W:0] diff;
  logic [POS_W:0] wrapped;

  // Borrow out of the extra bit means the raw difference went negative.
  always_comb begin
    diff    = {1'b0, to_pos} - {1'b0, from_pos};
    wrapped = diff[POS_W] ? (diff + STEPS_X) : diff;
    dist_up = wrapped[POS_W-1:0];
    dir_inc = (wrapped <= HALF_X);
  end

endmodule

// File: rtl/mmcm_phase_stepper.sv
// Walks an MMCM's dynamic fine phase shift to an absolute target by the
// shortest modular path, one PSEN/PSDONE handshake at a time.
module mmcm_phase_stepper
  import mmcm_ps_pkg::*;
#(
  parameter int unsigned POS_W           = 16,
  parameter int unsigned STEPS_PER_CYCLE = DEF_STEPS_PER_CYCLE,
  parameter int unsigned TIMEOUT_CYC     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  output logic             ps_en,
  output logic             ps_incdec,
  input  logic             ps_done,
  output logic [POS_W-1:0] cur_pos,
  output logic             busy,
  output logic             done_pulse,
  output logic             err_timeout,
  output logic             err_unlock,
  output logic             err_range
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [POS_W-1:0] STEPS_P  = POS_W'(STEPS_PER_CYCLE);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(STEPS_PER_CYCLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  ps_state_t        state;
  ps_state_t        next_state;
  logic [POS_W-1:0] target_q;
  logic [POS_W-1:0] plan_dist;
  logic [POS_W-1:0] step_pos;
  logic             plan_inc;
  logic             dir_inc_q;
  logic             target_bad;
  logic             at_target;
  logic             tmo_hit;
  logic             accept;
  logic [TMO_W-1:0] tmo_cnt;

  ps_wrap_dist #(
    .POS_W           (POS_W),
    .STEPS_PER_CYCLE (STEPS_PER_CYCLE)
  ) u_dist (
    .from_pos (cur_pos),
    .to_pos   (target_q),
    .dist_up  (plan_dist),
    .dir_inc  (plan_inc)
  );

  always_comb begin
    if (dir_inc_q) begin
      step_pos = (cur_pos == LAST_POS) ? '0 : cur_pos + POS_W'(1);
    end else begin
      step_pos = (cur_pos == '0) ? LAST_POS : cur_pos - POS_W'(1);
    end
  end

  assign target_bad = (target_q >= STEPS_P);
  assign at_target  = (step_pos == target_q);
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  // Gated by rst so every output reads 0 while reset is held.
  assign cmd_ready = (state == IDLE) && locked && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    next_state = state;
    ps_en      = 1'b0;
    ps_incdec  = 1'b0;
    done_pulse = 1'b0;
    if (!locked) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) next_state = PLAN;
        end
        PLAN: begin
          if (target_bad)             next_state = IDLE;
          else if (plan_dist == '0)   next_state = DONE;
          else                        next_state = ISSUE;
        end
        ISSUE: begin
          ps_en      = 1'b1;
          ps_incdec  = dir_inc_q;
          next_state = WAIT;
        end
        WAIT: begin
          if (ps_done)      next_state = at_target ? DONE : ISSUE;
          else if (tmo_hit) next_state = IDLE;
        end
        DONE: begin
          done_pulse = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_pos     <= '0;
      target_q    <= '0;
      dir_inc_q   <= 1'b0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
      err_unlock  <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      state <= next_state;
      if (!locked) begin
        // An MMCM reset throws away any accumulated dynamic shift.
        cur_pos <= '0;
        if (state != IDLE) err_unlock <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              target_q    <= cmd_target;
              err_timeout <= 1'b0;
              err_unlock  <= 1'b0;
              err_range   <= 1'b0;
            end
          end
          PLAN: begin
            if (target_bad) err_range <= 1'b1;
            else            dir_inc_q <= plan_inc;
          end
          ISSUE: begin
            tmo_cnt <= '0;
          end
          WAIT: begin
            if (ps_done)      cur_pos     <= step_pos;
            else if (tmo_hit) err_timeout <= 1'b1;
            else              tmo_cnt     <= tmo_cnt + TMO_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
